clock_mode_ctrl: RTL and testbench

//  Synchronous single-clock controller for the min:sec clock with alarm. Replaces gated/derived counter

---
 rtl/clock_mode_ctrl_pkg.sv | 42 ++++
 rtl/clock_mode_ctrl_btn_debounce.sv | 64 ++++++
 rtl/clock_mode_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// Shared encodings for the min:sec clock controller and its datapath:
// mode, edit position and alarm states, button indices and a width helper.
package clock_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_SETUP = 2'b01,
    MODE_ALARM = 2'b10
  } mode_e;

  typedef enum logic {
    POS_SEC = 1'b0,
    POS_MIN = 1'b1
  } pos_e;

  typedef enum logic {
    ALM_IDLE = 1'b0,
    ALM_RING = 1'b1
  } alm_e;

  // Button order inside the debounced vectors.
  localparam int NUM_BTN   = 4;
  localparam int BTN_MODE  = 0;
  localparam int BTN_POS   = 1;
  localparam int BTN_INC   = 2;
  localparam int BTN_ALARM = 3;

  // Mode sequence stepped by the mode button.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_CLOCK: next_mode = MODE_SETUP;
      MODE_SETUP: next_mode = MODE_ALARM;
      default:    next_mode = MODE_CLOCK;
    endcase
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter and a 1-cycle
// press pulse on the debounced released->pressed transition.
// Buttons are active-low; the debounced level resets to released (1).
module clock_mode_ctrl_btn_debounce
  import clock_mode_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_stable,
  output logic o_press
);

  localparam int CNT_W = width_for(DB_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_done;

  // The count only survives while the synchronised input keeps disagreeing
  // with the debounced level; DB_CYCLES such cycles in a row flip it.
  assign w_differs = (r_sync2 != r_stable);
  assign w_done    = w_differs && (r_cnt == CNT_W'(DB_CYCLES - 1));

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter, debounced level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_done && r_stable;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Single-clock controller for the min:sec clock with alarm. Debounces the
// four buttons, sequences CLOCK/SETUP/ALARM, the edit position, sw2
// auto-repeat and the alarm ring with its timeout.
// Interface contract: every *_inc output is a registered single-cycle
// enable; the datapath adds one on each clk edge where it samples 1.
// There is no back-pressure, so an enable is never held or retried.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DB_CYCLES  = 500_000,
  parameter int RING_SEC   = 30,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_sec_max,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic       o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_alarm_sec_inc,
  output logic       o_alarm_min_inc,
  output logic       o_alarm_en,
  output logic       o_buzz_en
);

  localparam int TICK_W = width_for(CLK_HZ - 1);
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W  = width_for(REP_MAX);
  localparam int RING_W = width_for(RING_SEC);

  logic [NUM_BTN-1:0] w_sw_n;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic               w_unused_stable;

  mode_e              r_mode;
  pos_e               r_pos;
  mode_e              w_mode_next;
  logic               w_mode_chg;
  logic               w_enter_setup;

  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;

  logic               r_rep_act;
  logic               r_rep_first;
  logic [REP_W-1:0]   r_rep_cnt;
  logic               w_rep_fire;
  logic               w_inc_evt;

  alm_e               r_alm;
  logic [RING_W-1:0]  r_ring_cnt;
  logic               r_match_d;
  logic               r_alarm_en;
  logic               r_buzz_en;
  logic               w_match_rise;

  logic               r_sec_inc;
  logic               r_min_inc;
  logic               r_alarm_sec_inc;
  logic               r_alarm_min_inc;

  assign w_sw_n = {i_sw3, i_sw2, i_sw1, i_sw0};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    clock_mode_ctrl_btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn_n (w_sw_n[g]),
      .o_stable(w_stable[g]),
      .o_press (w_press[g])
    );
  end

  // Only the increment button needs its held level (for auto-repeat).
  assign w_unused_stable = &{1'b0, w_stable[BTN_ALARM], w_stable[BTN_POS], w_stable[BTN_MODE]};

  assign w_mode_chg    = w_press[BTN_MODE];
  assign w_mode_next   = next_mode(r_mode);
  assign w_enter_setup = w_mode_chg && (w_mode_next == MODE_SETUP);

  // Time is frozen in SETUP: the counter sits at 0 so the first tick after
  // leaving SETUP comes a full second later.
  assign w_tick = (r_mode != MODE_SETUP) && (r_tick_cnt == TICK_W'(CLK_HZ - 1));

  // One-second tick counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (r_mode == MODE_SETUP || r_tick_cnt == TICK_W'(CLK_HZ - 1)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Mode/position FSM: mode button steps the mode and resets the edit
  // position; the position button is ignored in a mode-change cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_CLOCK;
      r_pos  <= POS_SEC;
    end else if (w_mode_chg) begin
      r_mode <= w_mode_next;
      r_pos  <= POS_SEC;
    end else if (w_press[BTN_POS]) begin
      r_pos <= (r_pos == POS_SEC) ? POS_MIN : POS_SEC;
    end
  end

  assign w_rep_fire = r_rep_act && !w_stable[BTN_INC] &&
                      (r_rep_first ? (r_rep_cnt == REP_W'(REPEAT_DLY - 1))
                                   : (r_rep_cnt == REP_W'(REPEAT_PER - 1)));

  // An increment event coinciding with a mode change is dropped.
  assign w_inc_evt = (w_press[BTN_INC] || w_rep_fire) && !w_mode_chg;

  // sw2 auto-repeat: armed by a press, first repeat after REPEAT_DLY, then
  // every REPEAT_PER while held; release or a mode change disarms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_act   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_mode_chg) begin
      r_rep_act   <= 1'b0;
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_press[BTN_INC]) begin
      r_rep_act   <= 1'b1;
      r_rep_first <= 1'b1;
      r_rep_cnt   <= '0;
    end else if (!r_rep_act || w_stable[BTN_INC]) begin
      r_rep_act <= 1'b0;
      r_rep_cnt <= '0;
    end else if (w_rep_fire) begin
      r_rep_first <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  // Increment enables: tick drives the time counters, sw2 events drive the
  // counter selected by mode and position. Both may fire in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_inc       <= 1'b0;
      r_min_inc       <= 1'b0;
      r_alarm_sec_inc <= 1'b0;
      r_alarm_min_inc <= 1'b0;
    end else begin
      r_sec_inc       <= w_tick;
      r_min_inc       <= w_tick && i_sec_max;
      r_alarm_sec_inc <= 1'b0;
      r_alarm_min_inc <= 1'b0;
      if (w_inc_evt) begin
        case (r_mode)
          MODE_SETUP: begin
            if (r_pos == POS_SEC) r_sec_inc <= 1'b1;
            else                  r_min_inc <= 1'b1;
          end
          MODE_ALARM: begin
            if (r_pos == POS_SEC) r_alarm_sec_inc <= 1'b1;
            else                  r_alarm_min_inc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_match_rise = i_alarm_match && !r_match_d;

  // Alarm FSM: ring on a match edge while armed (not in SETUP); stop on
  // sw3, after RING_SEC ticks, or on entering SETUP. sw3 arms/disarms in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alm      <= ALM_IDLE;
      r_ring_cnt <= '0;
      r_match_d  <= 1'b0;
      r_alarm_en <= 1'b0;
      r_buzz_en  <= 1'b0;
    end else begin
      r_match_d <= i_alarm_match;
      if (r_alm == ALM_IDLE) begin
        if (w_press[BTN_ALARM]) begin
          r_alarm_en <= !r_alarm_en;
        end
        if (w_match_rise && r_alarm_en && (r_mode != MODE_SETUP) && !w_enter_setup) begin
          r_alm      <= ALM_RING;
          r_buzz_en  <= 1'b1;
          r_ring_cnt <= '0;
        end
      end else begin
        if (w_press[BTN_ALARM] || w_enter_setup ||
            (w_tick && (r_ring_cnt == RING_W'(RING_SEC - 1)))) begin
          r_alm      <= ALM_IDLE;
          r_buzz_en  <= 1'b0;
          r_ring_cnt <= '0;
        end else if (w_tick) begin
          r_ring_cnt <= r_ring_cnt + 1'b1;
        end
      end
    end
  end

  assign o_mode          = r_mode;
  assign o_position      = r_pos;
  assign o_sec_inc       = r_sec_inc;
  assign o_min_inc       = r_min_inc;
  assign o_alarm_sec_inc = r_alarm_sec_inc;
  assign o_alarm_min_inc = r_alarm_min_inc;
  assign o_alarm_en      = r_alarm_en;
  assign o_buzz_en       = r_buzz_en;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with small timing parameters:
// CLK_HZ=10, DB_CYCLES=4, RING_SEC=3, REPEAT_DLY=20, REPEAT_PER=5.
// Inputs are driven and outputs sampled on the falling clock edge; "edge k"
// is the k-th rising edge after the negedge where a stimulus starts.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_sw0, i_sw1, i_sw2, i_sw3;
  logic       i_sec_max, i_alarm_match;
  logic [1:0] o_mode;
  logic       o_position, o_sec_inc, o_min_inc;
  logic       o_alarm_sec_inc, o_alarm_min_inc, o_alarm_en, o_buzz_en;

  int n_vec     = 0;
  int n_miscmp  = 0;
  logic [31:0] exp_q[$];

  clock_mode_ctrl #(
    .CLK_HZ    (10),
    .DB_CYCLES (4),
    .RING_SEC  (3),
    .REPEAT_DLY(20),
    .REPEAT_PER(5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sw0          (i_sw0),
    .i_sw1          (i_sw1),
    .i_sw2          (i_sw2),
    .i_sw3          (i_sw3),
    .i_sec_max      (i_sec_max),
    .i_alarm_match  (i_alarm_match),
    .o_mode         (o_mode),
    .o_position     (o_position),
    .o_sec_inc      (o_sec_inc),
    .o_min_inc      (o_min_inc),
    .o_alarm_sec_inc(o_alarm_sec_inc),
    .o_alarm_min_inc(o_alarm_min_inc),
    .o_alarm_en     (o_alarm_en),
    .o_buzz_en      (o_buzz_en)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {o_mode, o_position, o_sec_inc, o_min_inc,
            o_alarm_sec_inc, o_alarm_min_inc, o_alarm_en, o_buzz_en};
  endfunction

  // Drivers: reset with all buttons released; ends on a negedge with rst_n high.
  task automatic do_reset();
    rst_n = 1'b0;
    i_sw0 = 1'b1; i_sw1 = 1'b1; i_sw2 = 1'b1; i_sw3 = 1'b1;
    i_sec_max = 1'b0; i_alarm_match = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1: idle ticks every 10 cycles, minute carry with i_sec_max at 2nd tick
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      check_eq("tick_sec", 32'(o_sec_inc), 32'(k % 10 == 0));
      check_eq("tick_min", 32'(o_min_inc), 32'(k == 20));
      i_sec_max = (k == 19);
    end

    // 2: 3-cycle glitch ignored; 10-cycle press enters SETUP at edge 7
    do_reset();
    i_sw0 = 1'b0; wait_n(3); i_sw0 = 1'b1;
    wait_n(12);
    check_eq("glitch_mode", 32'(o_mode), 32'd0);
    i_sw0 = 1'b0;
    wait_n(6);
    check_eq("mode_edge6", 32'(o_mode), 32'd0);
    wait_n(1);
    check_eq("mode_edge7", 32'(o_mode), 32'd1);
    wait_n(3); i_sw0 = 1'b1;
    wait_n(12);
    check_eq("mode_release", 32'(o_mode), 32'd1);
    check_eq("pos_sec", 32'(o_position), 32'd0);
    i_sw1 = 1'b0; wait_n(8);
    check_eq("pos_min", 32'(o_position), 32'd1);
    i_sw1 = 1'b1; wait_n(10);

    // 3: SETUP/MIN, sw2 held 40 cycles: press + repeats at +20,+25,+30,+35
    exp_q = {32'd7, 32'd27, 32'd32, 32'd37, 32'd42};
    i_sw2 = 1'b0;
    for (int k = 1; k <= 55; k++) begin
      logic exp_pulse;
      @(negedge clk);
      exp_pulse = (exp_q.size() != 0) && (exp_q[0] == 32'(k));
      if (exp_pulse) void'(exp_q.pop_front());
      check_eq("rep_min_inc", 32'(o_min_inc), 32'(exp_pulse));
      check_eq("rep_sec_inc", 32'(o_sec_inc), 32'd0);
      check_eq("rep_alm_inc", 32'({o_alarm_sec_inc, o_alarm_min_inc}), 32'd0);
      if (k == 40) i_sw2 = 1'b1;
    end

    // 4: SETUP->ALARM at edge 7, first tick at edge 17 coincides with sw2 press
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check_eq("alm_mode", 32'(o_mode), (k >= 7) ? 32'd2 : 32'd1);
        check_eq("alm_pos", 32'(o_position), (k >= 7) ? 32'd0 : 32'd1);
        check_eq("alm_tick_sec", 32'(o_sec_inc), 32'(k == 17));
        check_eq("alm_sec_inc", 32'(o_alarm_sec_inc), 32'(k == 17));
        check_eq("alm_min_inc", 32'({o_min_inc, o_alarm_min_inc}), 32'd0);
      end
      i_sw0 = (k >= 8);
      i_sw2 = !(k >= 10 && k < 18);
    end

    // 5: arm, ring on match edge, 3-tick timeout, no retrigger, sw3 stop, reset mid-ring
    do_reset();
    for (int k = 0; k <= 78; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check_eq("ring_alarm_en", 32'(o_alarm_en), 32'(k >= 7));
        check_eq("ring_buzz", 32'(o_buzz_en),
                 32'((k >= 13 && k < 40) || (k >= 63 && k < 71) || (k >= 75)));
        check_eq("ring_tick", 32'(o_sec_inc), 32'(k % 10 == 0));
        check_eq("ring_pos", 32'(o_position), 32'(k >= 27));
      end
      i_sw3 = !((k < 8) || (k >= 64 && k < 72));
      i_sw1 = !(k >= 20 && k < 28);
      i_sw0 = !(k >= 74);
      i_alarm_match = (k >= 12 && k < 60) || (k >= 62 && k < 72) || (k >= 74);
    end
    rst_n = 1'b0;
    i_sw0 = 1'b1;
    #1;
    check_eq("midring_rst", 32'(outs()), 32'd0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(12);
    check_eq("post_rst_outs", 32'({o_mode, o_position, o_alarm_en, o_buzz_en}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
